// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode and R-type function code constants
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    // Non-R aluop codes; R-type ops are selected by the func field instead.
    localparam logic [4:0] ALUOP_ADD   = 5'b00000;
    localparam logic [4:0] ALUOP_SUB   = 5'b00001;
    localparam logic [4:0] ALUOP_AND   = 5'b00010;
    localparam logic [4:0] ALUOP_OR    = 5'b00011;
    localparam logic [4:0] ALUOP_XOR   = 5'b00100;
    localparam logic [4:0] ALUOP_LUI   = 5'b00101;
    localparam logic [4:0] ALUOP_SLT   = 5'b00110;
    localparam logic [4:0] ALUOP_SLTU  = 5'b00111;
    localparam logic [4:0] ALUOP_RTYPE = 5'b01001;

    localparam logic [5:0] FUNC_SLL   = 6'h00;
    localparam logic [5:0] FUNC_SRL   = 6'h02;
    localparam logic [5:0] FUNC_SRA   = 6'h03;
    localparam logic [5:0] FUNC_SLLV  = 6'h04;
    localparam logic [5:0] FUNC_SRLV  = 6'h06;
    localparam logic [5:0] FUNC_SRAV  = 6'h07;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_ADD   = 6'h20;
    localparam logic [5:0] FUNC_ADDU  = 6'h21;
    localparam logic [5:0] FUNC_SUB   = 6'h22;
    localparam logic [5:0] FUNC_SUBU  = 6'h23;
    localparam logic [5:0] FUNC_AND   = 6'h24;
    localparam logic [5:0] FUNC_OR    = 6'h25;
    localparam logic [5:0] FUNC_XOR   = 6'h26;
    localparam logic [5:0] FUNC_NOR   = 6'h27;
    localparam logic [5:0] FUNC_SLT   = 6'h2A;
    localparam logic [5:0] FUNC_SLTU  = 6'h2B;

endpackage

// File: rtl/alu_front_core.sv
// rtl/alu_front_core.sv - combinational ALU opcode decode and compute
module alu_front_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [4:0]       aluop,
    input  logic [5:0]       func,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2
);

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   lt_s_word;
    logic [WIDTH-1:0]   lt_u_word;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [4:0]         sh_amt;
    logic [WIDTH-1:0]   sll_res;
    logic [WIDTH-1:0]   srl_res;
    logic [WIDTH-1:0]   sra_res;

    assign sum  = op1 + op2;
    assign diff = op1 - op2;

    assign lt_s_word = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
    assign lt_u_word = {{(WIDTH-1){1'b0}}, (op1 < op2)};

    // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{WIDTH{op1[WIDTH-1]}}, op1} * {{WIDTH{op2[WIDTH-1]}}, op2};
    assign prod_u = {{WIDTH{1'b0}}, op1} * {{WIDTH{1'b0}}, op2};

    // func[2] separates the variable shifts (amount from rs) from the immediate ones.
    assign sh_amt  = func[2] ? op1[4:0] : shamt;
    assign sll_res = op2 << sh_amt;
    assign srl_res = op2 >> sh_amt;
    assign sra_res = $signed(op2) >>> sh_amt;

    always_comb begin
        out_1 = '0;
        out_2 = '0;
        if (aluop == ALUOP_RTYPE) begin
            case (func)
                FUNC_SLL,  FUNC_SLLV:  out_1 = sll_res;
                FUNC_SRL,  FUNC_SRLV:  out_1 = srl_res;
                FUNC_SRA,  FUNC_SRAV:  out_1 = sra_res;
                FUNC_MULT:             {out_2, out_1} = prod_s;
                FUNC_MULTU:            {out_2, out_1} = prod_u;
                FUNC_ADD,  FUNC_ADDU:  out_1 = sum;
                FUNC_SUB,  FUNC_SUBU:  out_1 = diff;
                FUNC_AND:              out_1 = op1 & op2;
                FUNC_OR:               out_1 = op1 | op2;
                FUNC_XOR:              out_1 = op1 ^ op2;
                FUNC_NOR:              out_1 = ~(op1 | op2);
                FUNC_SLT:              out_1 = lt_s_word;
                FUNC_SLTU:             out_1 = lt_u_word;
                default: begin
                    out_1 = '0;
                    out_2 = '0;
                end
            endcase
        end else begin
            case (aluop)
                ALUOP_ADD:  out_1 = sum;
                ALUOP_SUB:  out_1 = diff;
                ALUOP_AND:  out_1 = op1 & op2;
                ALUOP_OR:   out_1 = op1 | op2;
                ALUOP_XOR:  out_1 = op1 ^ op2;
                ALUOP_LUI:  out_1 = op2 << 16;
                ALUOP_SLT:  out_1 = lt_s_word;
                ALUOP_SLTU: out_1 = lt_u_word;
                default:    out_1 = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_front_reg.sv
// rtl/alu_front_reg.sv - ALU front end with one-cycle registered results
module alu_front_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       aluop,
    input  logic [5:0]       func,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2
);

    logic [WIDTH-1:0] res_1;
    logic [WIDTH-1:0] res_2;

    alu_front_core #(.WIDTH(WIDTH)) u_core (
        .aluop (aluop),
        .func  (func),
        .shamt (shamt),
        .op1   (op1),
        .op2   (op2),
        .out_1 (res_1),
        .out_2 (res_2)
    );

    // Asynchronous clear drops any result that was about to be captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_1 <= '0;
            out_2 <= '0;
        end else begin
            out_1 <= res_1;
            out_2 <= res_2;
        end
    end

endmodule

// File: tb/tb_alu_front_reg.sv
// tb/tb_alu_front_reg.sv - self-checking bench for alu_front_reg
module tb_alu_front_reg;

    logic        clk;
    logic        rst_n;
    logic [4:0]  aluop;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] out_1;
    logic [31:0] out_2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [4:0]  aluop;
        logic [5:0]  func;
        logic [4:0]  shamt;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs[$];

    alu_front_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .aluop (aluop),
        .func  (func),
        .shamt (shamt),
        .op1   (op1),
        .op2   (op2),
        .out_1 (out_1),
        .out_2 (out_2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint pow2(input int s);
        longint p = 1;
        for (int k = 0; k < s; k++) p = p * 2;
        return p;
    endfunction

    function automatic longint floor_div(input longint x, input longint d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    // Reference: arithmetic on 64-bit integers, returns {out_2, out_1}.
    function automatic logic [63:0] model(input logic [4:0] a_op, input logic [5:0] fn,
                                          input logic [4:0] sa_imm, input logic [31:0] x,
                                          input logic [31:0] y);
        longint unsigned a, b, m32;
        longint sa, sb;
        logic [31:0] lo, hi;
        a = x; b = y; sa = $signed(x); sb = $signed(y);
        m32 = 64'h1_0000_0000;
        lo = 0; hi = 0;
        if (a_op == 5'b01001) begin
            case (fn)
                6'h00: lo = 32'((b * longint'(pow2(int'(sa_imm)))) % m32);
                6'h04: lo = 32'((b * longint'(pow2(int'(x[4:0])))) % m32);
                6'h02: lo = 32'(b / longint'(pow2(int'(sa_imm))));
                6'h06: lo = 32'(b / longint'(pow2(int'(x[4:0]))));
                6'h03: lo = 32'(floor_div(sb, pow2(int'(sa_imm))));
                6'h07: lo = 32'(floor_div(sb, pow2(int'(x[4:0]))));
                6'h18: {hi, lo} = sa * sb;
                6'h19: {hi, lo} = a * b;
                6'h20, 6'h21: lo = 32'((a + b) % m32);
                6'h22, 6'h23: lo = 32'((a + m32 - b) % m32);
                6'h24: lo = x & y;
                6'h25: lo = x | y;
                6'h26: lo = x ^ y;
                6'h27: lo = ~(x | y);
                6'h2A: lo = (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: lo = (a < b) ? 32'd1 : 32'd0;
                default: begin lo = 0; hi = 0; end
            endcase
        end else begin
            case (a_op)
                5'd0: lo = 32'((a + b) % m32);
                5'd1: lo = 32'((a + m32 - b) % m32);
                5'd2: lo = x & y;
                5'd3: lo = x | y;
                5'd4: lo = x ^ y;
                5'd5: lo = 32'((b * 65536) % m32);
                5'd6: lo = (sa < sb) ? 32'd1 : 32'd0;
                5'd7: lo = (a < b) ? 32'd1 : 32'd0;
                default: lo = 0;
            endcase
        end
        return {hi, lo};
    endfunction

    task automatic check(input string name, input logic [31:0] e1, input logic [31:0] e2);
        n_checks++;
        if (out_1 !== e1 || out_2 !== e2) begin
            n_fail++;
            $display("FAIL %s: got out_1=%h out_2=%h, expected out_1=%h out_2=%h",
                     name, out_1, out_2, e1, e2);
        end
    endtask

    task automatic drive(input logic [4:0] a, input logic [5:0] f, input logic [4:0] s,
                         input logic [31:0] x, input logic [31:0] y);
        aluop = a; func = f; shamt = s; op1 = x; op2 = y;
    endtask

    task automatic add_vec(input string n, input logic [4:0] a, input logic [5:0] f,
                           input logic [4:0] s, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.name = n; v.aluop = a; v.func = f; v.shamt = s;
        v.op1 = x; v.op2 = y; v.exp1 = e1; v.exp2 = e2;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] prev1, prev2;
        logic [63:0] exp;
        logic [5:0]  legal_funcs [18];
        legal_funcs = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h18, 6'h19, 6'h20,
                        6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

        add_vec("sra",       5'b01001, 6'h03, 5'd5,  32'd17, 32'hFFFF0001, 32'hFFFFF800, 32'h0);
        add_vec("srl",       5'b01001, 6'h02, 5'd5,  32'd17, 32'hFFFF0001, 32'h07FFF800, 32'h0);
        add_vec("mult",      5'b01001, 6'h18, 5'd5,  32'd17, 32'hFFFF0001, 32'hFFEF0011, 32'hFFFFFFFF);
        add_vec("multu",     5'b01001, 6'h19, 5'd5,  32'd17, 32'hFFFF0001, 32'hFFEF0011, 32'h00000010);
        add_vec("addu_wrap", 5'b01001, 6'h21, 5'd0,  32'hFFFFFFFF, 32'd1, 32'h0, 32'h0);
        add_vec("sub_neg",   5'b01001, 6'h22, 5'd0,  32'd0, 32'd1, 32'hFFFFFFFF, 32'h0);
        add_vec("slt",       5'b01001, 6'h2A, 5'd0,  32'hFFFFFFFF, 32'd1, 32'd1, 32'h0);
        add_vec("sltu",      5'b01001, 6'h2B, 5'd0,  32'hFFFFFFFF, 32'd1, 32'd0, 32'h0);
        add_vec("nor_zero",  5'b01001, 6'h27, 5'd0,  32'd0, 32'd0, 32'hFFFFFFFF, 32'h0);
        add_vec("lui",       5'b00101, 6'h00, 5'd0,  32'd0, 32'h1234, 32'h12340000, 32'h0);
        add_vec("bad_func",  5'b01001, 6'h3F, 5'd7,  32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0);
        add_vec("sra_31",    5'b01001, 6'h03, 5'd31, 32'd0, 32'h80000000, 32'hFFFFFFFF, 32'h0);
        add_vec("sll_0",     5'b01001, 6'h00, 5'd0,  32'd0, 32'hA5A5F00F, 32'hA5A5F00F, 32'h0);
        add_vec("srav_31",   5'b01001, 6'h07, 5'd0,  32'd31, 32'h40000000, 32'h0, 32'h0);
        add_vec("srlv_0",    5'b01001, 6'h06, 5'd3,  32'h20, 32'h80000001, 32'h80000001, 32'h0);
        add_vec("i_add",     5'b00000, 6'h22, 5'd9,  32'd3, 32'd4, 32'd7, 32'h0);
        add_vec("i_sltu",    5'b00111, 6'h00, 5'd0,  32'd1, 32'hFFFFFFFF, 32'd1, 32'h0);
        add_vec("bad_aluop", 5'b11111, 6'h18, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);

        // Reset held low with a live multiply on the inputs.
        rst_n = 1'b0;
        drive(5'b01001, 6'h18, 5'd0, 32'd17, 32'hFFFF0001);
        #2;
        check("reset_start", 32'h0, 32'h0);
        @(negedge clk);
        check("reset_after_edge", 32'h0, 32'h0);
        rst_n = 1'b1;
        #1;
        check("reset_release_hold", 32'h0, 32'h0);
        @(negedge clk);
        check("reset_track", 32'hFFEF0011, 32'hFFFFFFFF);

        // Directed table; each entry also checks the previous result is still held.
        prev1 = 32'hFFEF0011; prev2 = 32'hFFFFFFFF;
        foreach (vecs[i]) begin
            drive(vecs[i].aluop, vecs[i].func, vecs[i].shamt, vecs[i].op1, vecs[i].op2);
            #1;
            check({"hold_", vecs[i].name}, prev1, prev2);
            @(negedge clk);
            check(vecs[i].name, vecs[i].exp1, vecs[i].exp2);
            prev1 = vecs[i].exp1; prev2 = vecs[i].exp2;
        end

        // Back-to-back SLLV / ADD alternation.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] e1;
            if (i % 2 == 0) begin
                drive(5'b01001, 6'h04, 5'd0, 32'd4, 32'd1);
                e1 = 32'h10;
            end else begin
                drive(5'b01001, 6'h20, 5'd0, 32'(i), 32'd100);
                e1 = 32'(i + 100);
            end
            #1;
            check("b2b_hold", prev1, prev2);
            @(negedge clk);
            check("b2b_result", e1, 32'h0);
            prev1 = e1; prev2 = 32'h0;
        end

        // Reset asserted mid-cycle discards the pending multiply.
        drive(5'b01001, 6'h19, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge clk);
        check("pre_reset_multu", 32'h00000001, 32'hFFFFFFFE);
        drive(5'b01001, 6'h18, 5'd0, 32'd17, 32'hFFFF0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", 32'h0, 32'h0);
        @(negedge clk);
        check("reset_hold_edge", 32'h0, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_track", 32'hFFEF0011, 32'hFFFFFFFF);

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [4:0]  a;
            logic [5:0]  f;
            logic [31:0] x, y;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 5)      a = 5'b01001;
            else if (sel < 9) a = 5'($urandom_range(0, 7));
            else              a = 5'($urandom);
            if ($urandom_range(0, 7) == 0) f = 6'($urandom);
            else                           f = legal_funcs[$urandom_range(0, 17)];
            case ($urandom_range(0, 5))
                0:       x = 32'hFFFFFFFF;
                1:       x = 32'h80000000;
                2:       x = 32'($urandom_range(0, 40));
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       y = 32'h0;
                1:       y = 32'h7FFFFFFF;
                2:       y = 32'hFFFF0001;
                default: y = $urandom;
            endcase
            drive(a, f, 5'($urandom), x, y);
            exp = model(a, f, shamt, x, y);
            @(negedge clk);
            check("random", exp[31:0], exp[63:32]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
